host_bus_master: RTL and testbench

FPGA-side initiator for the 16-bit asynchronous host bus: chip select, output enable, write enable, shared data. Converts single-word read/write requests from internal logic into correctly timed bus cycles with parameterised setup, strobe and hold phases. Drives an external SRAM-like peripheral, or the host-interface responder of another FPGA in loopback test. Data-bus tri-state is split into out, out-enable and in; the top level instantiates the pad buffer.

---
 rtl/host_bus_master_if.sv | 40 ++++
 rtl/host_bus_master.sv | 153 +++++++++++++++
 tb/tb_host_bus_master.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/host_bus_master_if.sv
// host_bus_master_if: request side and async host-bus pins of host_bus_master; nWAIT/err exist only with HOST_BUS_WAIT_EN
interface host_bus_master_if #(
    parameter int ADDR_W = 8
);
    logic              req;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [15:0]       req_wdata;
    logic              ready;
    logic [15:0]       rdata;
    logic              rvalid;
    logic              nCS;
    logic              nOE;
    logic              nWE;
    logic [ADDR_W-1:0] Haddr;
    logic [15:0]       Hdata_o;
    logic              Hdata_oe;
    logic [15:0]       Hdata_i;
`ifdef HOST_BUS_WAIT_EN
    logic              nWAIT;
    logic              err;
    modport master (
        input  req, req_we, req_addr, req_wdata, Hdata_i, nWAIT,
        output ready, rdata, rvalid, nCS, nOE, nWE, Haddr, Hdata_o, Hdata_oe, err
    );
    modport slave (
        output req, req_we, req_addr, req_wdata, Hdata_i, nWAIT,
        input  ready, rdata, rvalid, nCS, nOE, nWE, Haddr, Hdata_o, Hdata_oe, err
    );
`else
    modport master (
        input  req, req_we, req_addr, req_wdata, Hdata_i,
        output ready, rdata, rvalid, nCS, nOE, nWE, Haddr, Hdata_o, Hdata_oe
    );
    modport slave (
        output req, req_we, req_addr, req_wdata, Hdata_i,
        input  ready, rdata, rvalid, nCS, nOE, nWE, Haddr, Hdata_o, Hdata_oe
    );
`endif
endinterface

// File: rtl/host_bus_master.sv
// host_bus_master: single-word initiator for the 16-bit async host bus (setup/strobe/hold phases); HOST_BUS_WAIT_EN adds nWAIT strobe extension with timeout
module host_bus_master #(
    parameter int ADDR_W     = 8,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 3,
    parameter int HOLD_CYC   = 1
) (
    input logic CLK,
    input logic RST,
    host_bus_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYC - 1);
    localparam logic [7:0] STROBE_LD = 8'(STROBE_CYC - 1);
    localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYC - 1);

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] haddr_q, haddr_d;
    logic [15:0]       hdata_o_q, hdata_o_d, rdata_q, rdata_d;
    logic              ncs_q, ncs_d, noe_q, noe_d, nwe_q, nwe_d;
    logic              oe_q, oe_d, ready_q, ready_d, rvalid_q, rvalid_d;
    logic              stall, abort;

`ifdef HOST_BUS_WAIT_EN
    logic [1:0]  wait_sync_q, wait_sync_d;
    logic [15:0] wcnt_q, wcnt_d;
    logic        err_q, err_d;

    assign abort = wcnt_q == 16'hFFFF;
    assign stall = !wait_sync_q[1] && !abort;

    // nWAIT synchroniser, extension counter and one-cycle timeout flag
    always_comb begin
        wait_sync_d = {wait_sync_q[0], bus.nWAIT};
        wcnt_d      = state_q != STROBE ? 16'd0 : (cnt_q == 8'd0 && stall) ? wcnt_q + 16'd1 : wcnt_q;
        err_d       = state_q == STROBE && cnt_q == 8'd0 && abort;
    end

    // wait-path registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wait_sync_q <= 2'b11;
            wcnt_q      <= 16'd0;
            err_q       <= 1'b0;
        end else begin
            wait_sync_q <= wait_sync_d;
            wcnt_q      <= wcnt_d;
            err_q       <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign abort = 1'b0;
    assign stall = 1'b0;
`endif

    // next-state and next-output logic; every bus pin comes straight from a flop
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        haddr_d   = haddr_q;
        hdata_o_d = hdata_o_q;
        rdata_d   = rdata_q;
        ncs_d     = ncs_q;
        noe_d     = noe_q;
        nwe_d     = nwe_q;
        oe_d      = oe_q;
        ready_d   = ready_q;
        rvalid_d  = 1'b0;
        case (state_q)
            IDLE: if (bus.req) begin
                state_d   = SETUP;
                cnt_d     = SETUP_LD;
                we_d      = bus.req_we;
                haddr_d   = bus.req_addr;
                hdata_o_d = bus.req_we ? bus.req_wdata : hdata_o_q;
                ncs_d     = 1'b0;
                oe_d      = bus.req_we;
                ready_d   = 1'b0;
            end
            SETUP: if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
            else begin
                state_d = STROBE;
                cnt_d   = STROBE_LD;
                noe_d   = we_q;
                nwe_d   = !we_q;
            end
            STROBE: if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
            else if (!stall) begin
                state_d  = HOLD;
                cnt_d    = HOLD_LD;
                noe_d    = 1'b1;
                nwe_d    = 1'b1;
                rdata_d  = (!we_q && !abort) ? bus.Hdata_i : rdata_q;
                rvalid_d = !we_q && !abort;
            end
            HOLD: if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
            else begin
                state_d = IDLE;
                ncs_d   = 1'b1;
                oe_d    = 1'b0;
                ready_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and registered outputs; reset releases the bus immediately
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            we_q      <= 1'b0;
            haddr_q   <= '0;
            hdata_o_q <= 16'd0;
            rdata_q   <= 16'd0;
            ncs_q     <= 1'b1;
            noe_q     <= 1'b1;
            nwe_q     <= 1'b1;
            oe_q      <= 1'b0;
            ready_q   <= 1'b1;
            rvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            haddr_q   <= haddr_d;
            hdata_o_q <= hdata_o_d;
            rdata_q   <= rdata_d;
            ncs_q     <= ncs_d;
            noe_q     <= noe_d;
            nwe_q     <= nwe_d;
            oe_q      <= oe_d;
            ready_q   <= ready_d;
            rvalid_q  <= rvalid_d;
        end
    end

    assign bus.ready    = ready_q;
    assign bus.rdata    = rdata_q;
    assign bus.rvalid   = rvalid_q;
    assign bus.nCS      = ncs_q;
    assign bus.nOE      = noe_q;
    assign bus.nWE      = nwe_q;
    assign bus.Haddr    = haddr_q;
    assign bus.Hdata_o  = hdata_o_q;
    assign bus.Hdata_oe = oe_q;
endmodule

// File: tb/tb_host_bus_master.sv
// tb_host_bus_master: directed checks of default timing, back-to-back traffic, alternate timing params and async reset
module tb_host_bus_master;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int n_run = 0;
    int n_fail = 0;
    int cyc, cs_n, oe_n, we_n, doe_n, rv_n, rdy_n, oe_first, we_first, rv_first;
    int bad_n, rd_bad, fall_n, last_fall, gap_bad;
    int cs_t, oe_t, doe_t, rv_t, oe_first_t, rv_first_t;
    logic prev_cs;
    logic [7:0] exp_a;
    logic [15:0] exp_wd, exp_rd;
    logic we_v [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0] a_v [4] = '{8'h21, 8'h22, 8'h23, 8'h24};
    logic [15:0] d_v [4] = '{16'h1111, 16'hBEEF, 16'h2222, 16'hC0DE};

    always #5 CLK = ~CLK;

    host_bus_master_if #(.ADDR_W(8)) b ();
    host_bus_master_if #(.ADDR_W(8)) t ();

    host_bus_master dut (.CLK(CLK), .RST(RST), .bus(b));
    host_bus_master #(.SETUP_CYC(2), .STROBE_CYC(1), .HOLD_CYC(3)) dut_t (.CLK(CLK), .RST(RST), .bus(t));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        cyc = 0; cs_n = 0; oe_n = 0; we_n = 0; doe_n = 0; rv_n = 0; rdy_n = 0;
        oe_first = 0; we_first = 0; rv_first = 0; bad_n = 0; rd_bad = 0;
        fall_n = 0; last_fall = 0; gap_bad = 0; prev_cs = 1'b1;
        cs_t = 0; oe_t = 0; doe_t = 0; rv_t = 0; oe_first_t = 0; rv_first_t = 0;
    endtask

    task automatic watch(input int n);
        for (int i = 0; i < n; i++) begin
            cyc++;
            if (!b.nCS) cs_n++;
            if (!b.nOE) oe_n++;
            if (!b.nWE) we_n++;
            if (b.Hdata_oe) doe_n++;
            if (b.rvalid) rv_n++;
            if (b.ready) rdy_n++;
            if (!b.nOE && oe_first == 0) oe_first = cyc;
            if (!b.nWE && we_first == 0) we_first = cyc;
            if (b.rvalid && rv_first == 0) rv_first = cyc;
            if (!b.nCS && b.Haddr !== exp_a) bad_n++;
            if (b.Hdata_oe && b.Hdata_o !== exp_wd) bad_n++;
            if ((!b.nOE && !b.nWE) || (b.Hdata_oe && !b.nOE)) bad_n++;
            if (b.rvalid && b.rdata !== exp_rd) rd_bad++;
            if (!b.nCS && prev_cs) begin
                if (fall_n > 0 && cyc - last_fall != 6) gap_bad++;
                fall_n++;
                last_fall = cyc;
            end
            prev_cs = b.nCS;
            if (!t.nCS) cs_t++;
            if (!t.nOE) oe_t++;
            if (t.Hdata_oe) doe_t++;
            if (t.rvalid) rv_t++;
            if (!t.nOE && oe_first_t == 0) oe_first_t = cyc;
            if (t.rvalid && rv_first_t == 0) rv_first_t = cyc;
            b.Hdata_i = !b.nOE ? exp_rd : 16'hDEAD;
            t.Hdata_i = !t.nOE ? exp_rd : 16'hDEAD;
            @(negedge CLK);
        end
    endtask

    task automatic issue_b(input logic we, input logic [7:0] a, input logic [15:0] d);
        b.req = 1'b1; b.req_we = we; b.req_addr = a; b.req_wdata = d;
    endtask

    initial begin
        b.req = 1'b0; b.req_we = 1'b0; b.req_addr = 8'h0; b.req_wdata = 16'h0; b.Hdata_i = 16'hDEAD;
        t.req = 1'b0; t.req_we = 1'b0; t.req_addr = 8'h0; t.req_wdata = 16'h0; t.Hdata_i = 16'hDEAD;
`ifdef HOST_BUS_WAIT_EN
        b.nWAIT = 1'b1;
        t.nWAIT = 1'b1;
`endif
        exp_a = 8'h0; exp_wd = 16'h0; exp_rd = 16'h0;
        @(negedge CLK);
        check("rst_ncs", b.nCS, 1'b1);
        check("rst_ready", b.ready, 1'b1);
        check("rst_rdata", b.rdata, 16'h0);
        check("rst_haddr", b.Haddr, 8'h0);
        check("rst_doe", b.Hdata_oe, 1'b0);
        RST = 1'b0;
        @(negedge CLK);
        // single write at default timing
        issue_b(1'b1, 8'h3C, 16'hA55A);
        exp_a = 8'h3C; exp_wd = 16'hA55A;
        @(negedge CLK);
        b.req = 1'b0;
        clr();
        watch(6);
        check("wr_cs_low", cs_n, 5);
        check("wr_we_low", we_n, 3);
        check("wr_we_first", we_first, 2);
        check("wr_oe_low", oe_n, 0);
        check("wr_doe", doe_n, 5);
        check("wr_bus_bad", bad_n, 0);
        check("wr_ready", rdy_n, 1);
        // single read with an ignored request pulse mid-transaction
        issue_b(1'b0, 8'h10, 16'h0);
        exp_a = 8'h10; exp_rd = 16'h1234;
        @(negedge CLK);
        b.req = 1'b0;
        clr();
        watch(2);
        issue_b(1'b1, 8'h99, 16'h5555);
        watch(1);
        b.req = 1'b0;
        watch(3);
        check("rd_cs_low", cs_n, 5);
        check("rd_oe_low", oe_n, 3);
        check("rd_oe_first", oe_first, 2);
        check("rd_doe", doe_n, 0);
        check("rd_rv_cnt", rv_n, 1);
        check("rd_rv_first", rv_first, 5);
        check("rd_rdata", b.rdata, 16'h1234);
        check("rd_busy_ignored", fall_n, 1);
        check("rd_bus_bad", bad_n + rd_bad, 0);
        // back-to-back alternating write/read with req held high
        issue_b(we_v[0], a_v[0], d_v[0]);
        @(negedge CLK);
        clr();
        for (int k = 0; k < 4; k++) begin
            exp_a = a_v[k]; exp_wd = d_v[k]; exp_rd = d_v[k];
            if (k < 3) issue_b(we_v[k+1], a_v[k+1], d_v[k+1]);
            else b.req = 1'b0;
            watch(6);
        end
        check("b2b_txns", fall_n, 4);
        check("b2b_period", gap_bad, 0);
        check("b2b_cs_low", cs_n, 20);
        check("b2b_rv_cnt", rv_n, 2);
        check("b2b_we_low", we_n, 6);
        check("b2b_doe", doe_n, 10);
        check("b2b_bad", bad_n + rd_bad, 0);
        // read on the instance with SETUP=2, STROBE=1, HOLD=3
        t.req = 1'b1; t.req_we = 1'b0; t.req_addr = 8'h55;
        exp_rd = 16'h4321;
        @(negedge CLK);
        t.req = 1'b0;
        clr();
        watch(7);
        check("tp_cs_low", cs_t, 6);
        check("tp_oe_low", oe_t, 1);
        check("tp_oe_first", oe_first_t, 3);
        check("tp_rv_cnt", rv_t, 1);
        check("tp_rv_first", rv_first_t, 4);
        check("tp_doe", doe_t, 0);
        check("tp_rdata", t.rdata, 16'h4321);
        // asynchronous reset in the middle of a write strobe
        issue_b(1'b1, 8'h77, 16'h0F0F);
        exp_a = 8'h77; exp_wd = 16'h0F0F;
        @(negedge CLK);
        b.req = 1'b0;
        clr();
        watch(3);
        check("pre_rst_nwe", b.nWE, 1'b0);
        #2 RST = 1'b1;
        #1;
        check("arst_nwe", b.nWE, 1'b1);
        check("arst_ncs", b.nCS, 1'b1);
        check("arst_doe", b.Hdata_oe, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("post_rst_ready", b.ready, 1'b1);
        check("post_rst_rdata", b.rdata, 16'h0);
        check("post_rst_rdata_t", t.rdata, 16'h0);
        check("post_rst_haddr", b.Haddr, 8'h0);
        check("post_rst_ncs", b.nCS, 1'b1);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
